fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control decoder. It owns the program counter and the run/halt sequencing, and addresses the instruction memory. It splits the fetched 9-bit word into the opcode and branch_bits fields the decoder consumes. It applies the decoder's wpc_en, sel_pc_next and done outputs to advance, redirect or freeze the PC, and it generates the decoder's start input.

Parameters:
PC_W, 10, program counter / instruction memory address width
INSTR_W, 9, instruction width
OFF_W, 8, width of signed PC-relative offset from the ALU
P0_ADDR, 0, start address of program 0
P1_ADDR, 128, start address of program 1
P2_ADDR, 256, start address of program 2
P3_ADDR, 384, start address of program 3

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  testbench start request; level-sensitive
prog_sel  input  2  selects start address P0..P3, sampled while start=1
imem_data  input  INSTR_W  combinational instruction memory read data
wpc_en  input  1  PC write enable from decoder
sel_pc_next  input  1  decoder: branch or jump instruction
is_branch  input  1  decoder branch flag (0 with sel_pc_next=1 means jump)
cond_met  input  1  branch condition result from flag logic
pc_offset  input  OFF_W  signed offset from ALU (target = PC+1+offset)
done  input  1  decoder done flag
imem_addr  output  PC_W  instruction memory address (= pc)
opcode  output  3  instr[8:6]
branch_bits  output  2  instr[5:4]
instr  output  INSTR_W  full fetched word, for register/immediate fields
ctrl_start  output  1  start input to decoder
running  output  1  high in RUN
halted  output  1  high in HALT
cycle_count  output  16  RUN-cycle counter

Behaviour:
- States: IDLE, LOAD, RUN, HALT. Reset (async, any time) -> IDLE, pc=0, cycle_count=0, running=0, halted=0, ctrl_start=1.
- IDLE: start=1 -> LOAD. Otherwise stay; pc holds.
- LOAD: each cycle pc <= P[prog_sel]; cycle_count <= 0. start=0 -> RUN; pc keeps the last loaded address.
- RUN: start=1 -> LOAD (abort; no PC update this cycle). Else if done=1 -> HALT; pc frozen on the done instruction. Else if wpc_en=1, pc updates as below. Else pc holds.
- HALT: pc frozen; halted=1. start=1 -> LOAD. Otherwise stay.
- Priority in RUN: start > done > wpc_en.
- Taken = sel_pc_next & (~is_branch | cond_met).
- Taken: next pc = pc + 1 + sext(pc_offset), computed mod 2^PC_W.
- Not taken: next pc = pc + 1, mod 2^PC_W; the maximum address wraps to 0.
- Fetch is zero-latency: imem_addr = pc combinationally. instr = imem_data, and opcode/branch_bits are sliced combinationally in every state.
- ctrl_start = 1 in IDLE and LOAD, 0 in RUN and HALT. In HALT the done word stays on instr, so the decoder holds done=1.
- running = (state==RUN). halted = (state==HALT). Both are registered state decodes with no extra latency.
- cycle_count: +1 on every RUN cycle, including the cycle in which done is seen. Holds in HALT and IDLE. Cleared in LOAD. Saturates at 16'hFFFF.
- Reset asserted mid-RUN: state, pc and counter clear immediately, without waiting for a clock edge.

Test Plan:
- Reset then start=1 with prog_sel=1 for 3 cycles, then start=0 -> pc=128 in LOAD; RUN on the next edge; ctrl_start 1->0; sequential fetch of 128, 129, 130 with wpc_en=1.
- RUN at pc=200, sel_pc_next=1, is_branch=1, cond_met=0, pc_offset=8'hFC -> pc=201. Same with cond_met=1 -> pc=197.
- Jump at pc=10 (sel_pc_next=1, is_branch=0, cond_met=0), pc_offset=8'h05 -> pc=16. Wrap cases: pc=1023 not taken -> pc=0; pc=2, offset=8'hF0 -> pc=1011.
- done=1 at pc=57 after 40 RUN cycles -> HALT; pc stays 57 for 10 cycles; halted=1; cycle_count=41 held. Then start=1 with prog_sel=2 -> LOAD; pc=256; count=0.
- wpc_en=0 for 2 cycles in RUN -> pc holds while cycle_count still increments. Simultaneous start=1 and done=1 -> LOAD wins.
- Async reset pulsed between clock edges mid-RUN at pc=300 -> pc=0, IDLE, ctrl_start=1, all before the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, run/halt sequencing and
// the decoder start handshake. Fetch is zero-latency: the PC drives the
// instruction memory address directly and the returned word is sliced
// combinationally into the decoder fields.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; waiting for start, pc holds
// LOAD  | start held; pc reloaded from selected program base every cycle
// RUN   | executing; pc advances/redirects on wpc_en, counter running
// HALT  | done seen; pc frozen on the done word, counter held
module fetch_unit #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int OFF_W   = 8,
    parameter int P0_ADDR = 0,
    parameter int P1_ADDR = 128,
    parameter int P2_ADDR = 256,
    parameter int P3_ADDR = 384
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         prog_sel,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               wpc_en,
    input  logic               sel_pc_next,
    input  logic               is_branch,
    input  logic               cond_met,
    input  logic [OFF_W-1:0]   pc_offset,
    input  logic               done,
    output logic [PC_W-1:0]    imem_addr,
    output logic [2:0]         opcode,
    output logic [1:0]         branch_bits,
    output logic [INSTR_W-1:0] instr,
    output logic               ctrl_start,
    output logic               running,
    output logic               halted,
    output logic [15:0]        cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [PC_W-1:0] load_addr;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_target;
    logic            taken;
    logic [15:0]     cnt_inc;

    // Program base address selected by prog_sel.
    always_comb begin
        load_addr = PC_W'(P0_ADDR);
        case (prog_sel)
            2'd0: load_addr = PC_W'(P0_ADDR);
            2'd1: load_addr = PC_W'(P1_ADDR);
            2'd2: load_addr = PC_W'(P2_ADDR);
            2'd3: load_addr = PC_W'(P3_ADDR);
            default: load_addr = PC_W'(P0_ADDR);
        endcase
    end

    // Sequential and PC-relative targets; both wrap modulo the address space.
    assign off_ext   = {{(PC_W-OFF_W){pc_offset[OFF_W-1]}}, pc_offset};
    assign pc_inc    = pc_q + PC_W'(1);
    assign pc_target = pc_inc + off_ext;
    assign taken     = sel_pc_next & (~is_branch | cond_met);
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // Next-state, PC and counter selection; start beats done beats wpc_en in RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                pc_d  = load_addr;
                cnt_d = 16'd0;
                if (!start) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (start) begin
                    state_d = LOAD;
                end else if (done) begin
                    state_d = HALT;
                end else if (wpc_en) begin
                    pc_d = taken ? pc_target : pc_inc;
                end
            end
            HALT: begin
                if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and RUN-cycle counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = imem_data;
    assign opcode      = imem_data[INSTR_W-1 -: 3];
    assign branch_bits = imem_data[INSTR_W-4 -: 2];
    assign ctrl_start  = (state_q == IDLE) || (state_q == LOAD);
    assign running     = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of PC-update vectors fed through a scoreboard
// queue, plus directed sequences for start/load, halt, stall, abort and
// asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  prog_sel = 2'd0;
    logic [8:0]  imem_data;
    logic        wpc_en = 1'b0;
    logic        sel_pc_next = 1'b0;
    logic        is_branch = 1'b0;
    logic        cond_met = 1'b0;
    logic [7:0]  pc_offset = 8'd0;
    logic        done = 1'b0;
    logic [9:0]  imem_addr;
    logic [2:0]  opcode;
    logic [1:0]  branch_bits;
    logic [8:0]  instr;
    logic        ctrl_start;
    logic        running;
    logic        halted;
    logic [15:0] cycle_count;

    int errors = 0;
    int checks = 0;
    int sb_q[$];

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .imem_data(imem_data), .wpc_en(wpc_en), .sel_pc_next(sel_pc_next),
        .is_branch(is_branch), .cond_met(cond_met), .pc_offset(pc_offset),
        .done(done), .imem_addr(imem_addr), .opcode(opcode),
        .branch_bits(branch_bits), .instr(instr), .ctrl_start(ctrl_start),
        .running(running), .halted(halted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Instruction memory model: content is a fixed function of the address.
    assign imem_data = imem_addr[8:0] ^ 9'h15A;

    typedef struct {
        logic [1:0] psel;
        logic [7:0] setup_off;
        logic       sel;
        logic       isb;
        logic       cond;
        logic [7:0] off;
        logic       wpc;
        int         exp_pc;
    } vec_t;

    vec_t vecs[7];

    function automatic int base_addr(input logic [1:0] ps);
        case (ps)
            2'd0: return 0;
            2'd1: return 128;
            2'd2: return 256;
            default: return 384;
        endcase
    endfunction

    function automatic int rel_target(input int pc, input logic [7:0] off);
        int s;
        s = off[7] ? int'(off) - 256 : int'(off);
        return (pc + 1 + s + 1024) % 1024;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        start = 1'b0; wpc_en = 1'b0; sel_pc_next = 1'b0;
        is_branch = 1'b0; cond_met = 1'b0; pc_offset = 8'd0; done = 1'b0;
    endtask

    // From any state: LOAD for two cycles, then enter RUN at the base address.
    task automatic do_load(input logic [1:0] ps);
        clear_ctl();
        start = 1'b1;
        prog_sel = ps;
        step();
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        int exp_pc;
        int got;

        vecs[0] = '{2'd1, 8'd71,  1'b1, 1'b1, 1'b0, 8'hFC, 1'b1, 201};
        vecs[1] = '{2'd1, 8'd71,  1'b1, 1'b1, 1'b1, 8'hFC, 1'b1, 197};
        vecs[2] = '{2'd0, 8'd9,   1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 16};
        vecs[3] = '{2'd0, 8'hFE,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0};
        vecs[4] = '{2'd0, 8'd1,   1'b1, 1'b0, 1'b0, 8'hF0, 1'b1, 1011};
        vecs[5] = '{2'd3, 8'd0,   1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 385};
        vecs[6] = '{2'd2, 8'd16,  1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 146};

        // Reset state
        #2;
        chk("reset_pc", int'(imem_addr), 0);
        chk("reset_cnt", int'(cycle_count), 0);
        chk("reset_ctrl_start", int'(ctrl_start), 1);
        chk("reset_running", int'(running), 0);
        chk("reset_halted", int'(halted), 0);
        #10;
        reset = 1'b0;

        // Start with prog_sel=1 held for three cycles
        start = 1'b1;
        prog_sel = 2'd1;
        step();
        chk("load0_pc", int'(imem_addr), 0);
        chk("load0_ctrl_start", int'(ctrl_start), 1);
        chk("load0_running", int'(running), 0);
        step();
        chk("load1_pc", int'(imem_addr), 128);
        step();
        chk("load2_pc", int'(imem_addr), 128);
        start = 1'b0;
        wpc_en = 1'b1;
        step();
        chk("run_running", int'(running), 1);
        chk("run_ctrl_start", int'(ctrl_start), 0);
        chk("run_pc128", int'(imem_addr), 128);
        chk("run_instr128", int'(instr), int'(9'd128 ^ 9'h15A));
        chk("run_opcode128", int'(opcode), int'((9'd128 ^ 9'h15A) >> 6));
        chk("run_bbits128", int'(branch_bits), int'(((9'd128 ^ 9'h15A) >> 4) & 9'd3));
        step();
        chk("run_pc129", int'(imem_addr), 129);
        step();
        chk("run_pc130", int'(imem_addr), 130);
        chk("run_opcode130", int'(opcode), int'((9'd130 ^ 9'h15A) >> 6));
        chk("run_cnt2", int'(cycle_count), 2);

        // Table-driven PC update vectors through the scoreboard
        foreach (vecs[i]) begin
            do_load(vecs[i].psel);
            sel_pc_next = 1'b1; is_branch = 1'b0; wpc_en = 1'b1;
            pc_offset = vecs[i].setup_off;
            sb_q.push_back(rel_target(base_addr(vecs[i].psel), vecs[i].setup_off));
            step();
            got = int'(imem_addr);
            chk($sformatf("vec%0d_setup_pc", i), got, sb_q.pop_front());
            sel_pc_next = vecs[i].sel; is_branch = vecs[i].isb;
            cond_met = vecs[i].cond; pc_offset = vecs[i].off; wpc_en = vecs[i].wpc;
            sb_q.push_back(vecs[i].exp_pc);
            step();
            got = int'(imem_addr);
            chk($sformatf("vec%0d_pc", i), got, sb_q.pop_front());
        end

        // Halt at pc=57 after 40 RUN cycles
        do_load(2'd0);
        sel_pc_next = 1'b1; wpc_en = 1'b1; pc_offset = 8'd17;
        step();
        sel_pc_next = 1'b0;
        exp_pc = 18;
        for (int k = 0; k < 39; k++) begin
            step();
            exp_pc++;
        end
        chk("pre_done_pc", int'(imem_addr), exp_pc);
        chk("pre_done_cnt", int'(cycle_count), 40);
        done = 1'b1;
        step();
        chk("halt_halted", int'(halted), 1);
        chk("halt_running", int'(running), 0);
        chk("halt_ctrl_start", int'(ctrl_start), 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("halt_pc_%0d", k), int'(imem_addr), 57);
            chk($sformatf("halt_cnt_%0d", k), int'(cycle_count), 41);
            step();
        end
        chk("halt_still", int'(halted), 1);
        clear_ctl();
        start = 1'b1;
        prog_sel = 2'd2;
        step();
        chk("reload_halted", int'(halted), 0);
        chk("reload_ctrl_start", int'(ctrl_start), 1);
        step();
        chk("reload_pc", int'(imem_addr), 256);
        chk("reload_cnt", int'(cycle_count), 0);
        start = 1'b0;
        step();

        // Stall: wpc_en low, pc holds but counter keeps running
        do_load(2'd0);
        step();
        step();
        chk("stall_pc", int'(imem_addr), 0);
        chk("stall_cnt", int'(cycle_count), 2);
        start = 1'b1;
        done = 1'b1;
        step();
        chk("abort_running", int'(running), 0);
        chk("abort_halted", int'(halted), 0);
        chk("abort_ctrl_start", int'(ctrl_start), 1);
        clear_ctl();
        step();

        // Asynchronous reset mid-RUN at pc=300
        do_load(2'd2);
        sel_pc_next = 1'b1; wpc_en = 1'b1; pc_offset = 8'd43;
        step();
        clear_ctl();
        chk("pre_reset_pc", int'(imem_addr), 300);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_pc", int'(imem_addr), 0);
        chk("areset_ctrl_start", int'(ctrl_start), 1);
        chk("areset_running", int'(running), 0);
        chk("areset_cnt", int'(cycle_count), 0);
        #1;
        reset = 1'b0;
        step();
        chk("post_reset_idle", int'(ctrl_start), 1);
        chk("post_reset_pc", int'(imem_addr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
